pu_flow_pd_clr_ctl: RTL and testbench

Flow PD clear controller. It zeroes the whole per-flow PD region (2^WORD_NBITS words at `{fid, word}`) when the flow manager frees or allocates a flow id. It shares the flow PD RAM write port with the PU write arbiter: PU writes take priority, and a starvation counter guarantees clear progress. It sits beside the PU flow PD memory block; the memory wrapper muxes `cl_wr`/`cl_waddr`/`cl_wdata` onto the RAM write port whenever `cl_wr` is high.

---
 rtl/pu_flow_pd_clr_ctl.sv | 182 ++++++++++++++++++
 tb/tb_pu_flow_pd_clr_ctl.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_flow_pd_clr_ctl.sv
// Flow PD clear controller: zeroes a flow's PD words on free/alloc,
// sharing the RAM write port with the PU write arbiter.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   clr_req/clr_fid/clr_ready  clear request handshake (fid queue)
//   clr_done/clr_done_fid      one-cycle completion pulse with its fid
//   busy/busy_fid              activity flag and fid being cleared
//   pu_wr_req/pu_wr_hold       PU write present / PU write must stall
//   cl_wr/cl_waddr/cl_wdata    clear write strobe, address, zero data

`ifndef FID_NBITS
`define FID_NBITS 8
`endif
`ifndef FLOW_PD_NBITS
`define FLOW_PD_NBITS 5
`endif
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 64
`endif

module pu_flow_pd_clr_ctl #(
  parameter int FID_NBITS    = `FID_NBITS,
  parameter int WORD_NBITS   = `FLOW_PD_NBITS-2,
  parameter int WIDTH_NBITS  = `PU_WIDTH_NBITS,
  parameter int QDEPTH_NBITS = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr_req,
  input  logic [FID_NBITS-1:0]            clr_fid,
  output logic                            clr_ready,
  output logic                            clr_done,
  output logic [FID_NBITS-1:0]            clr_done_fid,
  output logic                            busy,
  output logic [FID_NBITS-1:0]            busy_fid,
  input  logic                            pu_wr_req,
  output logic                            pu_wr_hold,
  output logic                            cl_wr,
  output logic [FID_NBITS+WORD_NBITS-1:0] cl_waddr,
  output logic [WIDTH_NBITS-1:0]          cl_wdata
);

  localparam int QD = 1 << QDEPTH_NBITS;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [QDEPTH_NBITS:0] CNT_ONE  = 1;
  localparam logic [QDEPTH_NBITS:0] CNT_FULL =
    {1'b1, {QDEPTH_NBITS{1'b0}}};
  localparam logic [QDEPTH_NBITS-1:0] PTR_ONE = 1;
  localparam logic [WORD_NBITS-1:0] WORD_ONE = 1;
  localparam logic [SW-1:0] STV_ONE = 1;
  localparam logic [SW-1:0] STV_LIM = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [FID_NBITS-1:0]    q_mem [QD];
  logic [QDEPTH_NBITS-1:0] q_wp, q_rp;
  logic [QDEPTH_NBITS:0]   q_cnt_q, q_cnt_nxt;
  logic                    q_full, q_empty;
  logic                    push, pop;

  logic [FID_NBITS-1:0]  cur_fid_q;
  logic [WORD_NBITS-1:0] word_cnt_q;
  logic [SW-1:0]         starve_q;
  logic                  busy_q;
  logic                  yield;
  logic                  last_word;

  assign q_full    = (q_cnt_q == CNT_FULL);
  assign q_empty   = (q_cnt_q == '0);
  assign clr_ready = ~q_full;
  assign push      = clr_req & ~q_full;
  assign pop       = (state_q == IDLE) & ~q_empty;

  // PU write wins until the clear has yielded STV_LIM times in a row
  assign yield     = pu_wr_req & (starve_q < STV_LIM);
  assign last_word = &word_cnt_q;

  assign busy     = busy_q;
  assign cl_waddr = {busy_fid, word_cnt_q};
  assign cl_wdata = '0;

  always_comb begin
    q_cnt_nxt = q_cnt_q;
    if (push && !pop)
      q_cnt_nxt = q_cnt_q + CNT_ONE;
    else if (!push && pop)
      q_cnt_nxt = q_cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      q_mem[q_wp] <= clr_fid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wp    <= '0;
      q_rp    <= '0;
      q_cnt_q <= '0;
    end else begin
      if (push)
        q_wp <= q_wp + PTR_ONE;
      if (pop)
        q_rp <= q_rp + PTR_ONE;
      q_cnt_q <= q_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (!q_empty) state_nxt = CLEAR;
      CLEAR:   if (cl_wr && last_word) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cl_wr        = 1'b0;
    pu_wr_hold   = 1'b0;
    clr_done     = 1'b0;
    clr_done_fid = '0;
    busy_fid     = '0;
    unique case (state_q)
      CLEAR: begin
        busy_fid   = cur_fid_q;
        cl_wr      = ~yield;
        pu_wr_hold = ~yield & pu_wr_req;
      end
      DONE: begin
        busy_fid     = cur_fid_q;
        clr_done     = 1'b1;
        clr_done_fid = cur_fid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_fid_q  <= '0;
      word_cnt_q <= '0;
      starve_q   <= '0;
    end else if (pop) begin
      cur_fid_q  <= q_mem[q_rp];
      word_cnt_q <= '0;
      starve_q   <= '0;
    end else if (state_q == CLEAR) begin
      if (cl_wr) begin
        word_cnt_q <= word_cnt_q + WORD_ONE;
        starve_q   <= '0;
      end else begin
        starve_q <= starve_q + STV_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= 1'b0;
    else
      busy_q <= (q_cnt_nxt != '0) || (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_pu_flow_pd_clr_ctl.sv
// Bench for pu_flow_pd_clr_ctl: directed scenarios plus random
// traffic checked against a queue-based reference model.

module tb_pu_flow_pd_clr_ctl;

  localparam int FW = 4;
  localparam int WW = 3;
  localparam int DW = 16;
  localparam int QB = 2;
  localparam int SL = 8;
  localparam int NW = 1 << WW;
  localparam int QN = 1 << QB;

  logic          clk;
  logic          rst_n;
  logic          clr_req;
  logic [FW-1:0] clr_fid;
  logic          clr_ready;
  logic          clr_done;
  logic [FW-1:0] clr_done_fid;
  logic          busy;
  logic [FW-1:0] busy_fid;
  logic          pu_wr_req;
  logic          pu_wr_hold;
  logic          cl_wr;
  logic [FW+WW-1:0] cl_waddr;
  logic [DW-1:0] cl_wdata;

  int n_cmp = 0;
  int n_err = 0;

  pu_flow_pd_clr_ctl #(
    .FID_NBITS(FW), .WORD_NBITS(WW), .WIDTH_NBITS(DW),
    .QDEPTH_NBITS(QB), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .clr_req(clr_req), .clr_fid(clr_fid), .clr_ready(clr_ready),
    .clr_done(clr_done), .clr_done_fid(clr_done_fid),
    .busy(busy), .busy_fid(busy_fid),
    .pu_wr_req(pu_wr_req), .pu_wr_hold(pu_wr_hold),
    .cl_wr(cl_wr), .cl_waddr(cl_waddr), .cl_wdata(cl_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending fids, current phase, word and yield count
  int mq[$];
  int mph;
  int mfid;
  int mword;
  int mstarve;
  bit mbusy;

  function automatic bit m_wr();
    return (mph == 1) && !(pu_wr_req && (mstarve < SL));
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        mph = 0; mfid = 0; mword = 0; mstarve = 0; mbusy = 0;
      end else begin
        bit w;
        bit acc;
        w   = m_wr();
        acc = clr_req && (mq.size() < QN);
        case (mph)
          0: if (mq.size() > 0) begin
               mfid = mq.pop_front();
               mword = 0; mstarve = 0; mph = 1;
             end
          1: if (w) begin
               mstarve = 0;
               mword++;
               if (mword == NW) begin mword = 0; mph = 2; end
             end else mstarve++;
          default: mph = 0;
        endcase
        if (acc) mq.push_back(int'(clr_fid));
        mbusy = (mq.size() != 0) || (mph != 0);
      end
    end
  end

  // Continuous cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic          e_wr, e_hold, e_done, e_rdy;
        logic [FW-1:0] e_bf, e_df;
        logic [FW+WW-1:0] e_a;
        e_wr   = m_wr();
        e_hold = e_wr & pu_wr_req;
        e_done = (mph == 2);
        e_rdy  = (mq.size() < QN);
        e_bf   = (mph != 0) ? FW'(mfid) : '0;
        e_df   = e_done ? FW'(mfid) : '0;
        e_a    = {e_bf, WW'(mword)};
        n_cmp++;
        if ({cl_wr, pu_wr_hold, clr_done, clr_ready, busy} !==
            {e_wr, e_hold, e_done, e_rdy, mbusy}) begin
          n_err++;
          if (n_err < 30)
            $display("FAIL model_ctl t=%0t got wr/hold/done/rdy/busy=%b need %b",
              $time, {cl_wr, pu_wr_hold, clr_done, clr_ready, busy},
              {e_wr, e_hold, e_done, e_rdy, mbusy});
        end
        n_cmp++;
        if ({busy_fid, clr_done_fid, cl_waddr, cl_wdata} !==
            {e_bf, e_df, e_a, DW'(0)}) begin
          n_err++;
          if (n_err < 30)
            $display("FAIL model_data t=%0t got bf=%h df=%h a=%h d=%h need %h %h %h 0",
              $time, busy_fid, clr_done_fid, cl_waddr, cl_wdata, e_bf, e_df, e_a);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_timeout got busy=%b need 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr_req = 1'b0; clr_fid = '0; pu_wr_req = 1'b0;
    #12;
    n_cmp++;
    if ({clr_ready, busy, cl_wr, clr_done, pu_wr_hold} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctl got %b need 10000",
        {clr_ready, busy, cl_wr, clr_done, pu_wr_hold});
    end
    n_cmp++;
    if ({busy_fid, clr_done_fid, cl_waddr} !== '0) begin
      n_err++;
      $display("FAIL reset_data got %h %h %h need 0",
        busy_fid, clr_done_fid, cl_waddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int wk[$];
    logic [FW+WW-1:0] wa[$];
    int dk;
    int df;
    bit bok;
    tick();
    clr_req = 1'b1; clr_fid = 4'd5; pu_wr_req = 1'b0;
    tick();
    clr_req = 1'b0;
    dk = -1; df = -1; bok = 1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (cl_wr) begin wk.push_back(k); wa.push_back(cl_waddr); end
      if (clr_done) begin dk = k; df = int'(clr_done_fid); end
      if (k <= 10 && busy !== 1'b1) bok = 0;
      if (k == 11) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL single_busy_low got %b need 0", busy);
        end
      end
      tick();
    end
    n_cmp++;
    if (wk.size() != NW) begin
      n_err++;
      $display("FAIL single_nwr got %0d need %0d", wk.size(), NW);
    end
    for (int i = 0; i < wk.size(); i++) begin
      n_cmp++;
      if (wk[i] != 2 + i || wa[i] !== 7'(8'h28 + i)) begin
        n_err++;
        $display("FAIL single_wr%0d got k=%0d a=%h need k=%0d a=%h",
          i, wk[i], wa[i], 2 + i, 8'h28 + i);
      end
    end
    n_cmp++;
    if (dk != 10 || df != 5) begin
      n_err++;
      $display("FAIL single_done got k=%0d fid=%0d need k=10 fid=5", dk, df);
    end
    n_cmp++;
    if (!bok) begin
      n_err++;
      $display("FAIL single_busy_high got 0 need 1 through done");
    end
  endtask

  task automatic test_starve();
    int wk[$];
    int dk;
    bit hok;
    tick();
    clr_req = 1'b1; clr_fid = 4'd2; pu_wr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    dk = -1; hok = 1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (cl_wr) begin
        wk.push_back(k);
        if (pu_wr_hold !== 1'b1) hok = 0;
      end else if (pu_wr_hold !== 1'b0) hok = 0;
      if (clr_done) dk = k;
      tick();
    end
    pu_wr_req = 1'b0;
    n_cmp++;
    if (wk.size() != NW) begin
      n_err++;
      $display("FAIL starve_nwr got %0d need %0d", wk.size(), NW);
    end
    for (int j = 0; j < wk.size(); j++) begin
      n_cmp++;
      if (wk[j] != 2 + SL + (SL + 1) * j) begin
        n_err++;
        $display("FAIL starve_wr%0d got k=%0d need %0d",
          j, wk[j], 2 + SL + (SL + 1) * j);
      end
    end
    n_cmp++;
    if (dk != 2 + (SL + 1) * NW) begin
      n_err++;
      $display("FAIL starve_done got k=%0d need %0d", dk, 2 + (SL + 1) * NW);
    end
    n_cmp++;
    if (!hok) begin
      n_err++;
      $display("FAIL starve_hold got mismatch need hold only with write");
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    int held;
    int dk[$];
    int df[$];
    bit rdy;
    tick();
    idx = 0; held = 0; pu_wr_req = 1'b0;
    for (int c = 0; c < 120; c++) begin
      clr_req = (idx < 6);
      clr_fid = FW'(idx + 1);
      @(negedge clk);
      rdy = clr_ready;
      if (clr_req && !rdy) held++;
      if (clr_done) begin dk.push_back(c); df.push_back(int'(clr_done_fid)); end
      @(posedge clk);
      if (clr_req && rdy) idx++;
      #1;
    end
    clr_req = 1'b0;
    n_cmp++;
    if (idx != 6 || held == 0) begin
      n_err++;
      $display("FAIL b2b_accept got idx=%0d held=%0d need 6 and >0", idx, held);
    end
    n_cmp++;
    if (df.size() != 6) begin
      n_err++;
      $display("FAIL b2b_ndone got %0d need 6", df.size());
    end
    for (int i = 0; i < df.size(); i++) begin
      n_cmp++;
      if (df[i] != i + 1 || (i > 0 && dk[i] - dk[i-1] != NW + 2)) begin
        n_err++;
        $display("FAIL b2b_done%0d got fid=%0d gap=%0d need fid=%0d gap=%0d",
          i, df[i], (i > 0) ? dk[i] - dk[i-1] : 0, i + 1, NW + 2);
      end
    end
  endtask

  task automatic test_alternating();
    int seen[NW];
    bit vio;
    logic [FW-1:0] f;
    f = FW'($urandom_range(0, (1 << FW) - 1));
    foreach (seen[i]) seen[i] = 0;
    vio = 0;
    tick();
    clr_req = 1'b1; clr_fid = f; pu_wr_req = 1'b0;
    tick();
    clr_req = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      pu_wr_req = k[0];
      @(negedge clk);
      if (pu_wr_hold) vio = 1;
      if (cl_wr) begin
        if (pu_wr_req || cl_waddr[FW+WW-1:WW] !== f) vio = 1;
        seen[int'(cl_waddr[WW-1:0])]++;
      end
      tick();
    end
    pu_wr_req = 1'b0;
    n_cmp++;
    if (vio) begin
      n_err++;
      $display("FAIL alt_rules got violation need writes only when pu idle");
    end
    for (int i = 0; i < NW; i++) begin
      n_cmp++;
      if (seen[i] != 1) begin
        n_err++;
        $display("FAIL alt_word%0d got %0d writes need 1", i, seen[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nw;
    bit bad;
    tick();
    clr_req = 1'b1; clr_fid = 4'd6; pu_wr_req = 1'b0;
    tick();
    clr_req = 1'b0;
    nw = 0;
    for (int k = 0; k < 30 && nw < 4; k++) begin
      @(negedge clk);
      if (cl_wr) nw++;
      if (nw < 4) tick();
    end
    n_cmp++;
    if (nw != 4) begin
      n_err++;
      $display("FAIL rstmid_reach got %0d writes need 4", nw);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({clr_ready, busy, cl_wr, clr_done, pu_wr_hold} !== 5'b10000 ||
        {busy_fid, clr_done_fid, cl_waddr} !== '0) begin
      n_err++;
      $display("FAIL rstmid_async got %b %h %h %h need 10000 0 0 0",
        {clr_ready, busy, cl_wr, clr_done, pu_wr_hold},
        busy_fid, clr_done_fid, cl_waddr);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (clr_done || busy || !clr_ready || cl_wr) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL rstmid_after got activity need idle ready");
    end
  endtask

  task automatic test_duplicate();
    logic [FW+WW-1:0] wa[$];
    int df[$];
    tick();
    clr_req = 1'b1; clr_fid = 4'd3; pu_wr_req = 1'b0;
    tick();
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (cl_wr) wa.push_back(cl_waddr);
      if (clr_done) df.push_back(int'(clr_done_fid));
      tick();
    end
    n_cmp++;
    if (wa.size() != 2 * NW || df.size() != 2) begin
      n_err++;
      $display("FAIL dup_count got wr=%0d done=%0d need %0d 2",
        wa.size(), df.size(), 2 * NW);
    end
    for (int i = 0; i < wa.size(); i++) begin
      n_cmp++;
      if (wa[i] !== 7'(8'h18 + (i % NW))) begin
        n_err++;
        $display("FAIL dup_addr%0d got %h need %h", i, wa[i], 8'h18 + (i % NW));
      end
    end
    for (int i = 0; i < df.size(); i++) begin
      n_cmp++;
      if (df[i] != 3) begin
        n_err++;
        $display("FAIL dup_fid%0d got %0d need 3", i, df[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      clr_req   = ($urandom_range(0, 3) == 0);
      clr_fid   = FW'($urandom_range(0, (1 << FW) - 1));
      pu_wr_req = ($urandom_range(0, 2) != 0);
      tick();
    end
    clr_req = 1'b0;
    pu_wr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    wait_idle();
    test_starve();
    wait_idle();
    test_back_to_back();
    wait_idle();
    test_alternating();
    wait_idle();
    test_reset_mid();
    test_duplicate();
    wait_idle();
    test_random();
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
